rs_generic: RTL and testbench
=============================

RS_GENERIC -- requirements
Module: rs_generic

Interface
REQ-001 SHALL have parameter DEPTH, default 16; number of entries, a power of two from 2 to 64.
REQ-002 SHALL have parameter TAG_W, default 8; physical-register tag width.
REQ-003 SHALL have parameter PC_W, default 32; PC width.
REQ-004 SHALL have parameter NWB, default 7; number of wakeup (result broadcast) ports.
REQ-005 SHALL have parameter ZERO_TAG_READY, default 1; when 1, source tag 0 is always ready.
REQ-006 SHALL have port clk, input, 1 bit; the only clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-008 SHALL have port flush, input, 1 bit; synchronous squash (exception or mret).
REQ-009 SHALL have port in_valid, input, 1 bit; dispatch request.
REQ-010 SHALL have port in_ready, output, 1 bit; high when the station can accept.
REQ-011 SHALL have ports in_pc (PC_W), in_rd (TAG_W), in_src1 and in_src2 (TAG_W), and in_rdy (2 bits, [0]=src1, [1]=src2), all inputs; the dispatch payload.
REQ-012 SHALL have ports wb_valid (NWB bits) and wb_tag (NWB*TAG_W bits, port k at [k*TAG_W +: TAG_W]), inputs; result broadcasts.
REQ-013 SHALL have port out_valid, output, 1 bit; issue packet valid.
REQ-014 SHALL have port out_ready, input, 1 bit; the consumer accepts the packet.
REQ-015 SHALL have ports out_pc, out_rd, out_src1 and out_src2, outputs; the issued packet.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1 bits; occupied entries, excluding the output register.

Function
REQ-017 SHALL accept dispatch on the edge where in_valid && in_ready && !flush, writing one free entry.
REQ-018 SHALL drive in_ready = (count != DEPTH); no same-cycle credit from an entry being issued.
REQ-019 SHALL set each operand's ready bit at write to: in_rdy bit, OR a tag match on any valid wb port in the same cycle, OR (ZERO_TAG_READY and tag == 0).
REQ-020 SHALL, for each occupied entry, set a not-ready operand ready on any edge where some wb_valid[k] is high and wb_tag[k] equals that source tag; ready bits never clear while the entry lives.
REQ-021 SHALL record dispatch age; among occupied entries with both operands ready, the select SHALL pick the oldest accepted.
REQ-022 SHALL load the output register from the selected entry, and free that entry on the same edge, whenever (!out_valid || out_ready) and a ready entry exists.
REQ-023 SHALL hold out_valid and all out_* stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid on an edge where out_ready is high and no ready entry exists.
REQ-025 SHALL give latency: dispatch accepted at edge E0 with both operands ready, empty station and output -> out_valid high after edge E1.
REQ-026 SHALL NOT issue an entry on the edge it is written (no dispatch-to-issue bypass).
REQ-027 SHALL update count as +1 on accept, -1 on issue load, and unchanged when both occur on the same edge.
REQ-028 SHALL, on flush, clear all entries, count and out_valid at the next edge; flush dominates dispatch, wakeup and issue on that edge.
REQ-029 SHALL hold out_* data at their last values whenever out_valid is 0.
REQ-030 SHALL ignore wb ports whose wb_valid bit is 0, and SHALL allow multiple ports to match one entry.

Reset
REQ-031 SHALL, while reset is low, asynchronously clear all entries, age state and ready bits, and drive count=0, out_valid=0, out_pc/out_rd/out_src1/out_src2=0, in_ready=1.
REQ-032 SHALL have its first accept possible at the first rising edge after reset deasserts.

Verification
REQ-033 Basic issue: reset, then dispatch pc=0x100, rd=5, src1=3, src2=4, in_rdy=2'b11, out_ready=1 -> out_valid=1 one edge later with out_pc=0x100, out_rd=5; count returns 0.
REQ-034 Wakeup: dispatch src1=9, in_rdy=2'b10; wb_valid[2]=1, wb_tag[2]=9 two cycles later -> issue on the edge after the wakeup; with a same-cycle wakeup at dispatch -> issue one edge after accept.
REQ-035 Age order: dispatch A (not ready), then B and C (ready), then wake A -> issue order B, C, A; with all three ready at once -> A, B, C.
REQ-036 Full/backpressure: out_ready=0, dispatch DEPTH+1 ready entries -> in_ready=0 after DEPTH entries are held (count=16 at default); the extra request is not accepted; one out_ready pulse -> exactly one packet consumed, in_ready=1.
REQ-037 Flush mid-operation: 5 entries plus a held output, assert flush together with in_valid -> next edge count=0, out_valid=0, dispatch dropped.
REQ-038 Async reset: assert reset between edges with entries pending -> outputs clear immediately without a clock edge; ZERO_TAG_READY=1 with src1=0, in_rdy=2'b10 -> issues without wakeup.

Source files
------------

// File: rtl/rs_generic.sv
// rs_generic: out-of-order reservation station with wakeup and oldest-ready issue.
// Ports:
//    clk, reset (async, active-low), flush (sync squash)
//    in_valid/in_ready + in_pc, in_rd, in_src1, in_src2, in_rdy : dispatch
//    wb_valid, wb_tag (port k at [k*TAG_W +: TAG_W])              : result broadcasts
//    out_valid/out_ready + out_pc, out_rd, out_src1, out_src2     : issue register
//    count                                                         : occupied entries
module rs_generic #(
   parameter int DEPTH          = 16,
   parameter int TAG_W          = 8,
   parameter int PC_W           = 32,
   parameter int NWB            = 7,
   parameter int ZERO_TAG_READY = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PC_W-1:0]           in_pc,
   input  logic [TAG_W-1:0]          in_rd,
   input  logic [TAG_W-1:0]          in_src1,
   input  logic [TAG_W-1:0]          in_src2,
   input  logic [1:0]                in_rdy,
   input  logic [NWB-1:0]            wb_valid,
   input  logic [NWB*TAG_W-1:0]      wb_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PC_W-1:0]           out_pc,
   output logic [TAG_W-1:0]          out_rd,
   output logic [TAG_W-1:0]          out_src1,
   output logic [TAG_W-1:0]          out_src2,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0] valid, r1_q, r2_q, rdy, oldest;
   logic [PC_W-1:0]  pc_q [DEPTH];
   logic [TAG_W-1:0] rd_q [DEPTH];
   logic [TAG_W-1:0] s1_q [DEPTH];
   logic [TAG_W-1:0] s2_q [DEPTH];
   // older[i][j] set means entry i was accepted before entry j
   logic [DEPTH-1:0] older [DEPTH];
   logic [IW-1:0]    free_idx, sel_idx;
   logic             accept, load, new_r1, new_r2;

   function automatic logic hit(input logic [TAG_W-1:0] t);
      hit = 1'b0;
      for (int k = 0; k < NWB; k++)
         if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == t) hit = 1'b1;
   endfunction

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!valid[i]) free_idx = IW'(i);
      rdy = valid & r1_q & r2_q;
      // an entry is oldest-ready when no other ready entry is older than it
      oldest = '0;
      for (int i = 0; i < DEPTH; i++) begin
         oldest[i] = rdy[i];
         for (int j = 0; j < DEPTH; j++)
            if (rdy[j] && older[j][i]) oldest[i] = 1'b0;
      end
      sel_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         if (oldest[i]) sel_idx = IW'(i);
      in_ready = (count != CW'(DEPTH));
      accept   = in_valid && in_ready && !flush;
      load     = (|rdy) && (!out_valid || out_ready) && !flush;
      new_r1   = in_rdy[0] || hit(in_src1) || (ZERO_TAG_READY != 0 && in_src1 == '0);
      new_r2   = in_rdy[1] || hit(in_src2) || (ZERO_TAG_READY != 0 && in_src2 == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid     <= '0;
         r1_q      <= '0;
         r2_q      <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_rd    <= '0;
         out_src1  <= '0;
         out_src2  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]  <= '0;
            rd_q[i]  <= '0;
            s1_q[i]  <= '0;
            s2_q[i]  <= '0;
            older[i] <= '0;
         end
      end else if (flush) begin
         valid     <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && hit(s1_q[i])) r1_q[i] <= 1'b1;
            if (valid[i] && hit(s2_q[i])) r2_q[i] <= 1'b1;
         end
         if (load) begin
            valid[sel_idx] <= 1'b0;
            out_valid      <= 1'b1;
            out_pc         <= pc_q[sel_idx];
            out_rd         <= rd_q[sel_idx];
            out_src1       <= s1_q[sel_idx];
            out_src2       <= s2_q[sel_idx];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            valid[free_idx] <= 1'b1;
            pc_q[free_idx]  <= in_pc;
            rd_q[free_idx]  <= in_rd;
            s1_q[free_idx]  <= in_src1;
            s2_q[free_idx]  <= in_src2;
            r1_q[free_idx]  <= new_r1;
            r2_q[free_idx]  <= new_r2;
            older[free_idx] <= '0;
            // every entry already present is older than the newcomer
            for (int j = 0; j < DEPTH; j++)
               older[j][free_idx] <= valid[j];
         end
         count <= count + CW'(accept) - CW'(load);
      end
   end
endmodule

// File: tb/tb_rs_generic.sv
// tb_rs_generic: table, directed and random checks of rs_generic against a queue model.
module tb_rs_generic;
   localparam int DEPTH = 16;

   logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [31:0] in_pc = '0, out_pc;
   logic [7:0]  in_rd = '0, in_src1 = '0, in_src2 = '0, out_rd, out_src1, out_src2;
   logic [1:0]  in_rdy = '0;
   logic [6:0]  wb_valid = '0;
   logic [55:0] wb_tag = '0;
   logic [4:0]  count;

   always #5 clk = ~clk;

   rs_generic dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rd(in_rd), .in_src1(in_src1), .in_src2(in_src2), .in_rdy(in_rdy),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rd(out_rd), .out_src1(out_src1), .out_src2(out_src2), .count(count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  rd, s1, s2;
      bit          r1, r2;
   } ent_t;

   typedef struct {
      bit          iv;
      logic [31:0] pc;
      logic [7:0]  s1, s2;
      logic [1:0]  rdy;
      logic [6:0]  wbv;
      logic [7:0]  wbt;
      bit          e_ov;
      logic [31:0] e_pc;
      int          e_cnt;
   } vec_t;

   ent_t        q[$];
   bit          mov;
   logic [31:0] mpc;
   logic [7:0]  mrd, ms1, ms2;
   logic [31:0] hs[$];
   int          n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit woke(input logic [7:0] t);
      for (int k = 0; k < 7; k++)
         if (wb_valid[k] && wb_tag[k*8 +: 8] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      q.delete();
      mov = 0; mpc = '0; mrd = '0; ms1 = '0; ms2 = '0;
   endtask

   // queue kept oldest-first; issue takes the first fully ready element
   task automatic model_step();
      int   sel;
      bit   acc;
      ent_t e;
      if (flush) begin
         q.delete();
         mov = 0;
         return;
      end
      acc = in_valid && q.size() < DEPTH;
      sel = -1;
      foreach (q[i]) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
      if (sel >= 0 && (!mov || out_ready)) begin
         mov = 1; mpc = q[sel].pc; mrd = q[sel].rd; ms1 = q[sel].s1; ms2 = q[sel].s2;
         q.delete(sel);
      end else if (out_ready) begin
         mov = 0;
      end
      foreach (q[i]) begin
         if (woke(q[i].s1)) q[i].r1 = 1;
         if (woke(q[i].s2)) q[i].r2 = 1;
      end
      if (acc) begin
         e.pc = in_pc; e.rd = in_rd; e.s1 = in_src1; e.s2 = in_src2;
         e.r1 = in_rdy[0] || woke(in_src1) || in_src1 == 0;
         e.r2 = in_rdy[1] || woke(in_src2) || in_src2 == 0;
         q.push_back(e);
      end
   endtask

   task automatic chk_outs();
      chk("out_valid", out_valid, mov);
      chk("out_pc", out_pc, mpc);
      chk("out_rd", out_rd, mrd);
      chk("out_src1", out_src1, ms1);
      chk("out_src2", out_src2, ms2);
      chk("count", count, q.size());
      chk("in_ready", in_ready, q.size() != DEPTH);
   endtask

   task automatic cycle();
      chk_outs();
      if (out_valid && out_ready) hs.push_back(out_pc);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      in_valid = 0; flush = 0; wb_valid = '0; wb_tag = '0;
   endtask

   task automatic disp(input logic [31:0] pc, input logic [7:0] s1, input logic [1:0] rdy);
      in_valid = 1; in_pc = pc; in_rd = 8'd5; in_src1 = s1; in_src2 = 8'd4; in_rdy = rdy;
   endtask

   task automatic async_reset();
      clr();
      out_ready = 0;
      #2 reset = 0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_in_ready", in_ready, 1);
      model_reset();
      #1 reset = 1;
   endtask

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1, 32'h100, 8'd3, 8'd4, 2'b11, 7'h00, 8'd0, 0, 32'h000, 1};
      tbl[1]  = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h00, 8'd0, 1, 32'h100, 0};
      tbl[2]  = '{1, 32'h200, 8'd9, 8'd4, 2'b10, 7'h00, 8'd0, 0, 32'h100, 1};
      tbl[3]  = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h00, 8'd0, 0, 32'h100, 1};
      tbl[4]  = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h04, 8'd9, 0, 32'h100, 1};
      tbl[5]  = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h00, 8'd0, 1, 32'h200, 0};
      tbl[6]  = '{1, 32'h300, 8'd9, 8'd4, 2'b10, 7'h04, 8'd9, 0, 32'h200, 1};
      tbl[7]  = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h00, 8'd0, 1, 32'h300, 0};
      tbl[8]  = '{1, 32'h400, 8'd0, 8'd7, 2'b10, 7'h00, 8'd0, 0, 32'h300, 1};
      tbl[9]  = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h00, 8'd0, 1, 32'h400, 0};
      tbl[10] = '{1, 32'h500, 8'd9, 8'd4, 2'b10, 7'h00, 8'd9, 0, 32'h400, 1};
      tbl[11] = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h40, 8'd9, 0, 32'h400, 1};
      tbl[12] = '{0, 32'h000, 8'd0, 8'd4, 2'b00, 7'h00, 8'd0, 1, 32'h500, 0};

      model_reset();
      #1;
      chk("init_count", count, 0);
      chk("init_out_valid", out_valid, 0);
      chk("init_in_ready", in_ready, 1);
      @(posedge clk);
      #1 reset = 1;

      out_ready = 1;
      for (int i = 0; i < 13; i++) begin
         in_valid = tbl[i].iv; in_pc = tbl[i].pc; in_rd = 8'd5;
         in_src1 = tbl[i].s1; in_src2 = tbl[i].s2; in_rdy = tbl[i].rdy;
         wb_valid = tbl[i].wbv; wb_tag = {7{tbl[i].wbt}};
         cycle();
         chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
         chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
      end
      clr();
      cycle();

      hs.delete();
      disp(32'hA00, 8'd20, 2'b10); cycle();
      disp(32'hB00, 8'd3, 2'b11);  cycle();
      disp(32'hC00, 8'd3, 2'b11);  cycle();
      clr(); wb_valid = 7'h01; wb_tag = 56'd20; cycle();
      clr();
      for (int i = 0; i < 4; i++) cycle();
      chk("age_n", hs.size(), 3);
      if (hs.size() == 3) begin
         chk("age_0", hs[0], 32'hB00);
         chk("age_1", hs[1], 32'hC00);
         chk("age_2", hs[2], 32'hA00);
      end

      hs.delete();
      out_ready = 0;
      disp(32'hD00, 8'd3, 2'b11); cycle();
      disp(32'hE00, 8'd3, 2'b11); cycle();
      disp(32'hF00, 8'd3, 2'b11); cycle();
      clr(); out_ready = 1;
      for (int i = 0; i < 5; i++) cycle();
      chk("inord_n", hs.size(), 3);
      if (hs.size() == 3) begin
         chk("inord_0", hs[0], 32'hD00);
         chk("inord_1", hs[1], 32'hE00);
         chk("inord_2", hs[2], 32'hF00);
      end

      out_ready = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         disp(32'h1000 + i, 8'd3, 2'b11);
         cycle();
      end
      chk("full_count", count, DEPTH);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_pc", out_pc, 32'h1000);
      clr(); hs.delete(); out_ready = 1; cycle();
      out_ready = 0;
      chk("pulse_n", hs.size(), 1);
      chk("pulse_out_pc", out_pc, 32'h1001);
      chk("pulse_count", count, DEPTH - 1);
      chk("pulse_in_ready", in_ready, 1);
      cycle();

      async_reset();
      for (int i = 0; i < 6; i++) begin
         disp(32'h2000 + i, 8'd3, 2'b11);
         cycle();
      end
      clr();
      chk("pre_flush_count", count, 5);
      chk("pre_flush_ov", out_valid, 1);
      flush = 1; disp(32'h2F00, 8'd3, 2'b11); cycle();
      clr();
      chk("flush_count", count, 0);
      chk("flush_ov", out_valid, 0);
      cycle();
      chk("flush_drop", count, 0);

      for (int i = 0; i < 3; i++) begin
         disp(32'h3000 + i, 8'd3, 2'b11);
         cycle();
      end
      async_reset();
      cycle();

      for (int n = 0; n < 3000; n++) begin
         in_valid = $urandom_range(0, 9) < 7;
         in_pc = $urandom; in_rd = 8'($urandom);
         in_src1 = 8'($urandom_range(0, 15)); in_src2 = 8'($urandom_range(0, 15));
         in_rdy = 2'($urandom);
         wb_valid = 7'($urandom & $urandom);
         for (int k = 0; k < 7; k++) wb_tag[k*8 +: 8] = 8'($urandom_range(0, 15));
         out_ready = $urandom_range(0, 9) < 6;
         flush = $urandom_range(0, 199) == 0;
         cycle();
      end
      clr();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
